exec_resolve_stage: RTL and testbench
=====================================

Name: exec_resolve_stage

Overview:
- Execute-to-memory pipeline stage placed directly downstream of the integer ALU.
- Consumes the ALU result `y` and its 3-bit compare flags `bsr` ({eq, lt_signed, lt_unsigned}).
- Resolves conditional branches and jumps, and forms the writeback value.
- Registers everything behind a valid/ready handshake with a 2-entry skid buffer and issues a one-cycle fetch redirect.

Parameters:
WIDTH, 32, datapath and PC width in bits.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  discard all held and incoming ops this cycle
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept an op
alu_y  input  WIDTH  ALU result
alu_bsr  input  3  ALU flags: [2] eq, [1] signed lt, [0] unsigned lt
pc  input  WIDTH  PC of the op
funct3  input  3  branch condition select
is_branch  input  1  conditional branch
is_jump  input  1  JAL/JALR; alu_y carries the target
branch_target  input  WIDTH  precomputed conditional-branch target
rd  input  5  destination register
rd_we  input  1  op writes rd
out_valid  output  1  registered op valid
out_ready  input  1  downstream accepts
out_result  output  WIDTH  writeback value
out_rd  output  5  destination register
out_rd_we  output  1  writeback enable
redirect_valid  output  1  one-cycle fetch redirect pulse
redirect_pc  output  WIDTH  redirect address
out_misalign  output  1  target misaligned exception (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - All registered outputs and both buffer entries clear to 0 immediately.
  - in_ready is 0 while rst=1 and 1 in the first cycle after release.
- Accept: `acc = in_valid & in_ready & ~flush`.
- Branch condition decode, using alu_bsr:
  - 000 BEQ: eq
  - 001 BNE: ~eq
  - 100 BLT: lt
  - 101 BGE: ~lt
  - 110 BLTU: ltu
  - 111 BGEU: ~ltu
  - 010/011: not taken
- Taken: `taken = is_jump | (is_branch & cond)`. If both is_jump and is_branch are set, is_jump wins.
- Writeback value and enable:
  - Jump: out_result = pc + 4, truncated to WIDTH (wraps at 2^WIDTH).
  - Otherwise: out_result = alu_y.
  - out_rd_we = rd_we & ~is_branch. Branches never write.
- Redirect target:
  - Jump: alu_y with bit 0 cleared.
  - Taken branch: branch_target.
- Buffering:
  - Two entries, main (drives out_*) and skid.
  - in_ready = ~skid_valid, registered, so there is no combinational path from out_ready.
  - On acc: load main if main is empty or firing this cycle (out_valid & out_ready); otherwise load skid.
  - When main fires and skid is valid, skid moves to main in the same edge.
  - Ordering is strictly FIFO. Latency is 1 cycle from acc to out_valid when unstalled.
  - out_* hold stable while out_valid & ~out_ready.
- Redirect:
  - redirect_valid is asserted for exactly one cycle, the cycle after an acc with taken=1.
  - Timing is independent of downstream backpressure.
  - redirect_pc is valid only with redirect_valid; it holds its last value otherwise.
- Flush:
  - Clears main and skid valids at the next edge.
  - Blocks same-cycle acceptance and suppresses any redirect that acceptance would have produced.
  - A redirect already asserted this cycle completes.
  - Flush with out_ready=1 still presents the current out_* this cycle; consumers ignore it.
- Simultaneous acc and main fire with skid empty: the new op goes to main and out_valid stays 1.
- Reset mid-stall: both entries are lost and no redirect is generated.

Optional Feature:
Macro EXEC_RESOLVE_MISALIGN_EN.
- Defined (checks apply to taken ops only):
  - Jump: check the redirect target after bit 0 is cleared.
  - Taken branch: check branch_target.
  - If target[1] is set (branch_target[1:0] != 0 for branches), the op is registered with out_misalign=1 and out_rd_we=0.
  - No redirect pulse is issued for that op.
  - out_misalign travels with its op through the skid buffer.
- Undefined: out_misalign is tied 0 and targets are used unchecked.

Test Plan:
- BEQ, alu_bsr=3'b100, branch_target=0x0000_0200, out_ready=1 -> next cycle redirect_valid=1 and redirect_pc=0x200; out_valid=1 with out_rd_we=0; redirect_valid=0 the following cycle.
- BGEU, alu_bsr=3'b001 -> not taken, no redirect. Then BLT with alu_bsr=3'b010 -> taken.
- JAL, pc=0xFFFF_FFFC, alu_y=0x0000_0101, rd=1, rd_we=1 -> out_result=0x0000_0000 (wrap), redirect_pc=0x0000_0100.
- Backpressure: out_ready=0, send ops A (rd=3) then B (rd=4) back to back -> in_ready=0 after B is held in skid. Raise out_ready -> A then B on consecutive cycles, and in_ready returns to 1.
- Flush with a taken branch presented on in_valid while A is held in main -> no redirect, out_valid=0 next cycle. Assert rst mid-stall -> all outputs 0 asynchronously.
- With EXEC_RESOLVE_MISALIGN_EN defined: taken BNE, branch_target=0x0000_0102 -> out_misalign=1, no redirect. The same stimulus with the macro undefined -> redirect_pc=0x102 and out_misalign=0.

Source files
------------

// File: rtl/exec_resolve_stage.sv
// Execute-to-memory stage: resolves branches/jumps, forms writeback, 2-entry skid buffer, one-cycle fetch redirect.
// Optional target-misalignment exception enabled by defining EXEC_RESOLVE_MISALIGN_EN.
module exec_resolve_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_y,
  input  logic [2:0]       alu_bsr,
  input  logic [WIDTH-1:0] pc,
  input  logic [2:0]       funct3,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic [WIDTH-1:0] branch_target,
  input  logic [4:0]       rd,
  input  logic             rd_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             out_misalign
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       rd;
    logic             rd_we;
    logic             mis;
  } entry_t;

  entry_t           main_q, main_d, skid_q, skid_d, new_e;
  logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic             in_ready_q, in_ready_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic             is_br, cond, taken, misalign, acc, fire;
  logic [WIDTH-1:0] target;

  // Op resolution; a jump overrides a simultaneous branch flag.
  always_comb begin
    is_br = is_branch & ~is_jump;
    case (funct3)
      3'b000:  cond = alu_bsr[2];
      3'b001:  cond = ~alu_bsr[2];
      3'b100:  cond = alu_bsr[1];
      3'b101:  cond = ~alu_bsr[1];
      3'b110:  cond = alu_bsr[0];
      3'b111:  cond = ~alu_bsr[0];
      default: cond = 1'b0;
    endcase
    taken    = is_jump | (is_br & cond);
    target   = is_jump ? {alu_y[WIDTH-1:1], 1'b0} : branch_target;
    misalign = 1'b0;
`ifdef EXEC_RESOLVE_MISALIGN_EN
    misalign = taken & (is_jump ? target[1] : (branch_target[1:0] != 2'b00));
`endif
    new_e.result = is_jump ? (pc + WIDTH'(4)) : alu_y;
    new_e.rd     = rd;
    new_e.rd_we  = rd_we & ~is_br & ~misalign;
    new_e.mis    = misalign;
  end

  always_comb begin
    acc      = in_valid & in_ready_q & ~flush;
    fire     = main_v_q & out_ready;
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (fire | ~main_v_q) begin
      // Main slot frees up: skid has priority to keep FIFO order.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (acc) begin
        main_d   = new_e;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (acc) begin
      skid_d   = new_e;
      skid_v_d = 1'b1;
    end
    in_ready_d       = ~skid_v_d;
    redirect_valid_d = acc & taken & ~misalign;
    redirect_pc_d    = redirect_valid_d ? target : redirect_pc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q           <= '0;
      skid_q           <= '0;
      main_v_q         <= 1'b0;
      skid_v_q         <= 1'b0;
      in_ready_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      main_q           <= main_d;
      skid_q           <= skid_d;
      main_v_q         <= main_v_d;
      skid_v_q         <= skid_v_d;
      in_ready_q       <= in_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = main_v_q;
  assign out_result     = main_q.result;
  assign out_rd         = main_q.rd;
  assign out_rd_we      = main_q.rd_we;
  assign out_misalign   = main_q.mis;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exec_resolve_stage.sv
// Bench for exec_resolve_stage: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_exec_resolve_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, is_branch, is_jump, rd_we;
  logic [31:0] alu_y, pc, branch_target, out_result, redirect_pc;
  logic [2:0]  alu_bsr, funct3;
  logic [4:0]  rd, out_rd;
  logic        out_valid, out_ready, out_rd_we, redirect_valid, out_misalign;

  int checks = 0;
  int failures = 0;

  exec_resolve_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_y(alu_y), .alu_bsr(alu_bsr), .pc(pc), .funct3(funct3),
    .is_branch(is_branch), .is_jump(is_jump), .branch_target(branch_target),
    .rd(rd), .rd_we(rd_we), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        br, jp;
    logic [2:0]  bsr;
    logic [31:0] pcv, y, tgt;
    logic [4:0]  rdv;
    logic        we;
    logic [31:0] e_res;
    logic        e_we, e_rv;
    logic [31:0] e_rpc;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        mis;
  } exp_t;

  vec_t vecs[7];
  exp_t q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f3, input logic br, input logic jp, input logic [2:0] bsr,
                       input logic [31:0] pcv, input logic [31:0] y, input logic [31:0] tgt,
                       input logic [4:0] rdv, input logic we);
    funct3 = f3; is_branch = br; is_jump = jp; alu_bsr = bsr;
    pc = pcv; alu_y = y; branch_target = tgt; rd = rdv; rd_we = we;
  endtask

  // Reference semantics of one op, straight from the condition table and writeback rules.
  function automatic void model_op(input logic [2:0] f3, input logic br, input logic jp,
                                   input logic [2:0] bsr, input logic [31:0] pcv, input logic [31:0] y,
                                   input logic [31:0] tgt, input logic we,
                                   output logic [31:0] res, output logic owe, output logic tk,
                                   output logic [31:0] rtgt, output logic mis);
    bit eq, lt, ltu, c, is_b;
    eq = bsr[2]; lt = bsr[1]; ltu = bsr[0];
    case (f3)
      3'd0: c = eq;
      3'd1: c = !eq;
      3'd4: c = lt;
      3'd5: c = !lt;
      3'd6: c = ltu;
      3'd7: c = !ltu;
      default: c = 0;
    endcase
    is_b = br && !jp;
    tk   = jp || (is_b && c);
    res  = jp ? pcv + 32'd4 : y;
    rtgt = jp ? (y & ~32'd1) : tgt;
    mis  = 1'b0;
`ifdef EXEC_RESOLVE_MISALIGN_EN
    if (tk) mis = jp ? rtgt[1] : (tgt % 4 != 0);
`endif
    owe = we && !is_b && !mis;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);

    vecs[0] = '{"beq_taken", 3'd0, 1, 0, 3'b100, 32'h100, 32'h1234, 32'h200, 5'd5, 1, 32'h1234, 0, 1, 32'h200, 0};
    vecs[1] = '{"bgeu_not", 3'd7, 1, 0, 3'b001, 32'h104, 32'h55, 32'h300, 5'd6, 1, 32'h55, 0, 0, 32'h0, 0};
    vecs[2] = '{"blt_taken", 3'd4, 1, 0, 3'b010, 32'h108, 32'h66, 32'h300, 5'd6, 0, 32'h66, 0, 1, 32'h300, 0};
    vecs[3] = '{"jal_wrap", 3'd0, 0, 1, 3'b000, 32'hFFFF_FFFC, 32'h101, 32'h0, 5'd1, 1, 32'h0, 1, 1, 32'h100, 0};
`ifdef EXEC_RESOLVE_MISALIGN_EN
    vecs[4] = '{"bne_mis", 3'd1, 1, 0, 3'b000, 32'h10C, 32'h77, 32'h102, 5'd2, 1, 32'h77, 0, 0, 32'h0, 1};
`else
    vecs[4] = '{"bne_mis", 3'd1, 1, 0, 3'b000, 32'h10C, 32'h77, 32'h102, 5'd2, 1, 32'h77, 0, 1, 32'h102, 0};
`endif
    vecs[5] = '{"alu_op", 3'd0, 0, 0, 3'b111, 32'h110, 32'hDEAD_BEEF, 32'h0, 5'd7, 1, 32'hDEAD_BEEF, 1, 0, 32'h0, 0};
    vecs[6] = '{"f3_010", 3'd2, 1, 0, 3'b111, 32'h114, 32'h88, 32'h500, 5'd8, 1, 32'h88, 0, 0, 32'h0, 0};

    // Reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_misalign", {31'd0, out_misalign}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vector table
    foreach (vecs[i]) begin
      drive(vecs[i].f3, vecs[i].br, vecs[i].jp, vecs[i].bsr, vecs[i].pcv, vecs[i].y,
            vecs[i].tgt, vecs[i].rdv, vecs[i].we);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      $display("vec %s: result=0x%08h rd_we=%0d redirect=%0d pc=0x%08h mis=%0d",
               vecs[i].name, out_result, out_rd_we, redirect_valid, redirect_pc, out_misalign);
      chk({vecs[i].name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].name, "_result"}, out_result, vecs[i].e_res);
      chk({vecs[i].name, "_rd"}, {27'd0, out_rd}, {27'd0, vecs[i].rdv});
      chk({vecs[i].name, "_rd_we"}, {31'd0, out_rd_we}, {31'd0, vecs[i].e_we});
      chk({vecs[i].name, "_misalign"}, {31'd0, out_misalign}, {31'd0, vecs[i].e_mis});
      chk({vecs[i].name, "_redir"}, {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
      if (vecs[i].e_rv) chk({vecs[i].name, "_redir_pc"}, redirect_pc, vecs[i].e_rpc);
      tick();
      chk({vecs[i].name, "_redir_off"}, {31'd0, redirect_valid}, 32'd0);
      chk({vecs[i].name, "_drained"}, {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: A then B held, drained in order
    out_ready = 1'b0;
    drive(3'd0, 0, 0, 3'd0, 32'h200, 32'hA, 32'h0, 5'd3, 1);
    in_valid = 1'b1;
    tick();
    chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_a_rd", {27'd0, out_rd}, 32'd3);
    chk("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
    drive(3'd0, 0, 0, 3'd0, 32'h204, 32'hB, 32'h0, 5'd4, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_a_held_rd", {27'd0, out_rd}, 32'd3);
    chk("bp_a_held_res", out_result, 32'hA);
    tick();
    chk("bp_stall_rd", {27'd0, out_rd}, 32'd3);
    chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    $display("bp drain: A fired, now rd=%0d res=0x%08h", out_rd, out_result);
    chk("bp_b_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_b_rd", {27'd0, out_rd}, 32'd4);
    chk("bp_b_res", out_result, 32'hB);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with taken branch presented while A is held
    out_ready = 1'b0;
    drive(3'd0, 0, 0, 3'd0, 32'h300, 32'hA, 32'h0, 5'd3, 1);
    in_valid = 1'b1;
    tick();
    drive(3'd0, 1, 0, 3'b100, 32'h304, 32'h0, 32'h400, 5'd0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_no_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-stall with both entries full
    drive(3'd0, 0, 0, 3'd0, 32'h308, 32'hC, 32'h0, 5'd9, 1);
    in_valid = 1'b1;
    tick();
    drive(3'd0, 0, 1, 3'd0, 32'h30C, 32'h800, 32'h0, 5'd10, 1);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("midrst_redirect_pc", redirect_pc, 32'd0);
    chk("midrst_result", out_result, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("postrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("postrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("postrst_redirect", {31'd0, redirect_valid}, 32'd0);

    // Random traffic against the queue model
    begin
      logic        rv_exp;
      logic [31:0] rpc_exp;
      logic [31:0] res, rtgt;
      logic        owe, tk, mis, acc, fire;
      exp_t        e;
      rv_exp = 1'b0;
      rpc_exp = 32'd0;
      for (int n = 0; n < 600; n++) begin
        chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
        chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
        chk("rnd_redirect_valid", {31'd0, redirect_valid}, {31'd0, rv_exp});
        chk("rnd_redirect_pc", redirect_pc, rpc_exp);
        if (q.size() > 0) begin
          chk("rnd_result", out_result, q[0].res);
          chk("rnd_rd", {27'd0, out_rd}, {27'd0, q[0].rd});
          chk("rnd_rd_we", {31'd0, out_rd_we}, {31'd0, q[0].we});
          chk("rnd_misalign", {31'd0, out_misalign}, {31'd0, q[0].mis});
        end

        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 15) == 0);
        is_jump   = ($urandom_range(0, 5) == 0);
        is_branch = !is_jump && ($urandom_range(0, 2) == 0);
        funct3    = 3'($urandom_range(0, 7));
        alu_bsr   = 3'($urandom_range(0, 7));
        pc        = $urandom & ~32'd3;
        alu_y     = $urandom;
        branch_target = ($urandom & ~32'd3) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
        rd        = 5'($urandom_range(0, 31));
        rd_we     = ($urandom_range(0, 1) == 1);

        model_op(funct3, is_branch, is_jump, alu_bsr, pc, alu_y, branch_target, rd_we,
                 res, owe, tk, rtgt, mis);
        acc  = in_valid && (q.size() < 2) && !flush;
        fire = (q.size() > 0) && out_ready;
        if (fire && !flush) begin
          e = q.pop_front();
          $display("rnd out: rd=%0d we=%0d res=0x%08h mis=%0d", e.rd, e.we, e.res, e.mis);
        end
        if (flush) q.delete();
        if (acc) begin
          e.res = res; e.rd = rd; e.we = owe; e.mis = mis;
          q.push_back(e);
        end
        rv_exp = acc && tk && !mis;
        if (rv_exp) rpc_exp = rtgt;
        tick();
      end
      in_valid = 1'b0;
      flush = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
